// File: rtl/program_sequencer.sv
// program_sequencer: two-cycle fetch/execute controller owning the PC and return stack.
// Optional SEQ_STACK_GUARD_EN turns stack overflow/underflow into a sticky fault.
module program_sequencer #(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        step,
    input  logic [15:0]                 instr,
    input  logic [ADDR_W-1:0]           target,
    input  logic                        cond,
    output logic [ADDR_W-1:0]           pc,
    output logic                        acc_en,
    output logic                        store_en,
    output logic                        exec_valid,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                        halted,
    output logic                        fault
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                oneshot_q, oneshot_d;
    logic                halted_q, halted_d;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   tgt_q;
    logic                cnd_q;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

    logic                push;
    logic [ADDR_W-1:0]   ret_addr;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [SP_W-1:0]     sp_m1;
    logic                full;
    logic                empty;
    logic                op_acc;
    logic                op_call;
    logic                op_store;
    logic                op_ret;
    logic                unused_instr;

`ifdef SEQ_STACK_GUARD_EN
    logic                fault_q, fault_d;
`endif

    assign unused_instr = ^instr[13:0];

    assign op_acc   = (op_q == 2'b00);
    assign op_call  = (op_q == 2'b01);
    assign op_store = (op_q == 2'b10);
    assign op_ret   = (op_q == 2'b11);

    // Index wraps modulo depth, so a push when full lands on the oldest slot
    // and a pop when empty reads the top slot.
    assign sp_m1    = sp_q - SP_W'(1);
    assign wr_idx   = sp_q[IDX_W-1:0];
    assign rd_idx   = sp_m1[IDX_W-1:0];
    assign full     = (sp_q == SP_FULL);
    assign empty    = (sp_q == '0);
    assign ret_addr = pc_q + ADDR_W'(1) + ADDR_W'(cnd_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        oneshot_d = oneshot_q;
        halted_d  = halted_q;
        push      = 1'b0;
`ifdef SEQ_STACK_GUARD_EN
        fault_d   = fault_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else if (step) begin
                    state_d   = S_FETCH;
                    oneshot_d = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d   = (run && !oneshot_q) ? S_FETCH : S_IDLE;
                oneshot_d = 1'b0;
                unique case (1'b1)
                    op_acc, op_store: begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                    op_call: begin
                        if (tgt_q == pc_q) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
`ifdef SEQ_STACK_GUARD_EN
                        else if (full) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end
`endif
                        else begin
                            push = 1'b1;
                            pc_d = tgt_q;
                            sp_d = full ? sp_q : sp_q + SP_W'(1);
                        end
                    end
                    op_ret: begin
`ifdef SEQ_STACK_GUARD_EN
                        if (empty) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            pc_d = stack_q[rd_idx];
                            sp_d = sp_m1;
                        end
`else
                        pc_d = stack_q[rd_idx];
                        sp_d = empty ? sp_q : sp_m1;
`endif
                    end
                    default: ;
                endcase
            end
            S_HALT, S_FAULT: ;
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            sp_q      <= '0;
            oneshot_q <= 1'b0;
            halted_q  <= 1'b0;
            op_q      <= 2'b00;
            tgt_q     <= '0;
            cnd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            oneshot_q <= oneshot_d;
            halted_q  <= halted_d;
            if (state_q == S_FETCH) begin
                op_q  <= instr[15:14];
                tgt_q <= target;
                cnd_q <= cond;
            end
        end
    end

`ifdef SEQ_STACK_GUARD_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset && push) begin
            stack_q[wr_idx] <= ret_addr;
        end
    end

    assign pc         = pc_q;
    assign sp         = sp_q;
    assign halted     = halted_q;
    assign exec_valid = (state_q == S_EXEC);
    assign acc_en     = (state_q == S_EXEC) && op_acc;
    assign store_en   = (state_q == S_EXEC) && op_store;

endmodule
